pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the RV32 core. It replaces the single testbench-driven hold_flag/jump_flag pair with an arbitrated, registered controller. Multiple hold requesters (ex, load-use detector, bus wait, ...) feed it. It merges them with a jump request from ex, emits one hold level plus a registered jump/flush sequence to pc_reg, if_id and id_ex, and tracks stall length.

Parameters:
NUM_REQ, 3, number of independent hold-request channels (1..8)
HOLD_W, 3, width of a hold level; levels 0=HOLD_NONE, 1=HOLD_PC, 2=HOLD_IF, 3=HOLD_ID
PC_W, 32, jump address width
FLUSH_CYCLES, 2, cycles flush_o stays high after a jump (1..15)
CNT_W, 8, width of stall counter
MAX_STALL, 64, watchdog limit in cycles (used only with STALL_WDT_EN)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-high
jump_flag_i  in  1  jump/branch taken request from ex
jump_addr_i  in  PC_W  jump target
hold_req_i  in  NUM_REQ  per-channel hold request valid
hold_lvl_i  in  NUM_REQ*HOLD_W  per-channel requested level; channel k at bits [k*HOLD_W +: HOLD_W]
hold_flag_o  out  HOLD_W  merged hold level to pc_reg/if_id/id_ex
jump_flag_o  out  1  registered one-cycle jump pulse to pc_reg
jump_addr_o  out  PC_W  registered jump target; valid when jump_flag_o=1
flush_o  out  1  invalidate if_id/id_ex contents (insert NOP)
busy_o  out  1  1 while state != IDLE
stall_cnt_o  out  CNT_W  consecutive cycles with hold_flag_o != 0, saturating
wdt_o  out  1  sticky stall-watchdog flag (tied 0 without STALL_WDT_EN)

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0: hold_flag_o=HOLD_NONE, jump_addr_o=0, stall_cnt_o=0, wdt_o=0. State=IDLE, flush counter=0. Reset asserted mid-flush or mid-stall aborts immediately. No residual pulse after release.
- All outputs are registered. Latency is one clock from input sample to output.
- Merge: lvl_m = maximum hold_lvl_i over channels with hold_req_i=1. lvl_m=0 if none are set. A channel whose hold_req_i=0 is ignored regardless of its level. Levels above 3 are clamped to 3.
- FSM states: IDLE, FLUSH, STALL.
  - IDLE: jump_flag_i=1 -> FLUSH; else lvl_m!=0 -> STALL; else stay.
  - FLUSH: entered with jump_flag_o=1 for exactly the first cycle, jump_addr_o latched, flush_o=1, flush counter loaded with FLUSH_CYCLES. Counter decrements each cycle. When it reaches 0: -> STALL if lvl_m!=0, else -> IDLE. flush_o is high for exactly FLUSH_CYCLES cycles.
  - STALL: hold_flag_o=lvl_m each cycle; jump_flag_i=1 -> FLUSH; lvl_m==0 -> IDLE, with hold_flag_o=0 the next cycle.
- Priority: jump beats hold. On the cycle jump_flag_i=1, the next hold_flag_o = HOLD_NONE so pc_reg loads the target. During FLUSH, hold_flag_o = lvl_m except in the jump_flag_o cycle, where it is forced to 0.
- Back-to-back jump during FLUSH: restarts the flush counter, pulses jump_flag_o again, updates jump_addr_o. Flush length then counts from the newest jump.
- Held jump_flag_i (multi-cycle) is treated as a new jump every cycle.
- stall_cnt_o: increments each cycle the next hold_flag_o != 0 and saturates at 2^CNT_W-1 (no wrap). It clears to 0 on the cycle hold_flag_o becomes 0.
- busy_o = (state != IDLE), registered with state.

Optional Feature:
STALL_WDT_EN
- Defined: when stall_cnt_o reaches MAX_STALL, wdt_o is set sticky until reset. The FSM forces hold_flag_o=HOLD_NONE for one cycle (the forced release) and clears stall_cnt_o. The stall may then re-enter.
- Undefined: wdt_o is tied 0, no forced release, and stalls may last indefinitely.

Test Plan:
- Reset release, no requests, 20 cycles -> all outputs 0, busy_o=0.
- hold_req_i=3'b101, ch0 lvl=1, ch2 lvl=3, for 5 cycles, then 0 -> hold_flag_o=3 from cycle+1 for 5 cycles; stall_cnt_o counts 1..5, then 0; busy_o tracks.
- jump_flag_i pulse with addr 0x00000004, FLUSH_CYCLES=2 -> next cycle jump_flag_o=1, jump_addr_o=0x4, hold_flag_o=0; flush_o high exactly 2 cycles; then IDLE.
- Jump while ch1 holds lvl=2 -> jump cycle shows hold_flag_o=0, flush_o 2 cycles, then STALL with hold_flag_o=2.
- Second jump (addr 0x20) one cycle after first -> jump_flag_o pulses twice, jump_addr_o=0x20, flush_o continuous 3 cycles total.
- STALL_WDT_EN, MAX_STALL=64, constant lvl=1 -> at count 64 wdt_o=1 sticky, hold_flag_o=0 one cycle, stall_cnt_o restarts at 1. Assert rst mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the RV32 core.
// Merges several hold requesters and the ex-stage jump request into a single
// registered hold level, a one-cycle jump pulse with its target, and a flush
// window for if_id/id_ex. It also counts consecutive stalled cycles.
// Optional feature macro: STALL_WDT_EN enables the stall watchdog (sticky
// wdt_o plus a one-cycle forced release once the stall count hits MAX_STALL).
module pipe_ctrl #(
   parameter int NUM_REQ      = 3,
   parameter int HOLD_W       = 3,
   parameter int PC_W         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 8,
   parameter int MAX_STALL    = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       jump_flag_i,
   input  logic [PC_W-1:0]            jump_addr_i,
   input  logic [NUM_REQ-1:0]         hold_req_i,
   input  logic [NUM_REQ*HOLD_W-1:0]  hold_lvl_i,
   output logic [HOLD_W-1:0]          hold_flag_o,
   output logic                       jump_flag_o,
   output logic [PC_W-1:0]            jump_addr_o,
   output logic                       flush_o,
   output logic                       busy_o,
   output logic [CNT_W-1:0]           stall_cnt_o,
   output logic                       wdt_o
);

   localparam int FC_W = 4;
   localparam logic [HOLD_W-1:0] HOLD_NONE = '0;
   localparam logic [HOLD_W-1:0] HOLD_ID   = HOLD_W'(3);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

`ifdef STALL_WDT_EN
   localparam bit WDT_EN = 1'b1;
`else
   localparam bit WDT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
   logic [HOLD_W-1:0]   hold_flag_q, hold_flag_d;
   logic                jump_flag_q, jump_flag_d;
   logic [PC_W-1:0]     jump_addr_q, jump_addr_d;
   logic                flush_q, flush_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic                wdt_q, wdt_d;

   logic [HOLD_W-1:0]   lvl_m;
   logic                wdt_trip;

   // Merge the active hold channels into the highest requested level, clamped to HOLD_ID
   always_comb begin
      logic [HOLD_W-1:0] ch_lvl;
      lvl_m  = HOLD_NONE;
      ch_lvl = HOLD_NONE;
      for (int k = 0; k < NUM_REQ; k++) begin
         ch_lvl = hold_lvl_i[k*HOLD_W +: HOLD_W];
         if (ch_lvl > HOLD_ID) begin
            ch_lvl = HOLD_ID;
         end
         if (hold_req_i[k] && (ch_lvl > lvl_m)) begin
            lvl_m = ch_lvl;
         end
      end
   end

   // Watchdog trips when the visible stall count has reached the limit
   always_comb begin
      wdt_trip = WDT_EN && ({{(32-CNT_W){1'b0}}, stall_cnt_q} == 32'(MAX_STALL));
   end

   // Next-state and next-output logic; a jump request always wins over any hold
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      hold_flag_d = lvl_m;
      jump_flag_d = 1'b0;
      jump_addr_d = jump_addr_q;
      flush_d     = 1'b0;
      stall_cnt_d = '0;
      wdt_d       = wdt_q;

      if (jump_flag_i) begin
         state_d     = FLUSH;
         flush_cnt_d = FC_W'(FLUSH_CYCLES);
         jump_flag_d = 1'b1;
         jump_addr_d = jump_addr_i;
         flush_d     = 1'b1;
         hold_flag_d = HOLD_NONE;
      end else begin
         case (state_q)
            IDLE: begin
               if (lvl_m != HOLD_NONE) begin
                  state_d = STALL;
               end
            end
            FLUSH: begin
               flush_cnt_d = flush_cnt_q - 1'b1;
               if (flush_cnt_q > FC_W'(1)) begin
                  flush_d = 1'b1;
               end else if (lvl_m != HOLD_NONE) begin
                  state_d = STALL;
               end else begin
                  state_d = IDLE;
               end
            end
            STALL: begin
               if (lvl_m == HOLD_NONE) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (hold_flag_d != HOLD_NONE) begin
         stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + 1'b1;
      end

      if (wdt_trip) begin
         wdt_d       = 1'b1;
         hold_flag_d = HOLD_NONE;
         stall_cnt_d = '0;
         if (state_d == STALL) begin
            state_d = IDLE;
         end
      end
   end

   // Busy simply reflects whether the upcoming state is anything but IDLE
   always_comb begin
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset clears everything immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         hold_flag_q <= HOLD_NONE;
         jump_flag_q <= 1'b0;
         jump_addr_q <= '0;
         flush_q     <= 1'b0;
         busy_q      <= 1'b0;
         stall_cnt_q <= '0;
         wdt_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         hold_flag_q <= hold_flag_d;
         jump_flag_q <= jump_flag_d;
         jump_addr_q <= jump_addr_d;
         flush_q     <= flush_d;
         busy_q      <= busy_d;
         stall_cnt_q <= stall_cnt_d;
         wdt_q       <= wdt_d;
      end
   end

   assign hold_flag_o = hold_flag_q;
   assign jump_flag_o = jump_flag_q;
   assign jump_addr_o = jump_addr_q;
   assign flush_o     = flush_q;
   assign busy_o      = busy_q;
   assign stall_cnt_o = stall_cnt_q;
   assign wdt_o       = wdt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl.
// A driver applies directed and random stimulus on the falling edge and pushes
// the reference model's expected registered response; an independent monitor
// pops and compares after every rising edge.
module tb_pipe_ctrl;

   localparam int NUM_REQ      = 3;
   localparam int HOLD_W       = 3;
   localparam int PC_W         = 32;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 8;
   localparam int MAX_STALL    = 64;
   localparam int LVL_W        = NUM_REQ*HOLD_W;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                jump_flag_i = 1'b0;
   logic [PC_W-1:0]     jump_addr_i = '0;
   logic [NUM_REQ-1:0]  hold_req_i = '0;
   logic [LVL_W-1:0]    hold_lvl_i = '0;
   logic [HOLD_W-1:0]   hold_flag_o;
   logic                jump_flag_o;
   logic [PC_W-1:0]     jump_addr_o;
   logic                flush_o;
   logic                busy_o;
   logic [CNT_W-1:0]    stall_cnt_o;
   logic                wdt_o;

   typedef struct packed {
      logic [HOLD_W-1:0] hold;
      logic              jf;
      logic [PC_W-1:0]   addr;
      logic              flush;
      logic              busy;
      logic [CNT_W-1:0]  cnt;
      logic              wdt;
   } resp_t;

   resp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state: flush cycles still owed, stall length, sticky watchdog, last target
   int              m_flush_left = 0;
   int              m_cnt = 0;
   bit              m_wdt = 1'b0;
   logic [PC_W-1:0] m_addr = '0;

   pipe_ctrl #(
      .NUM_REQ(NUM_REQ), .HOLD_W(HOLD_W), .PC_W(PC_W),
      .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
   ) dut (
      .clk(clk), .rst(rst),
      .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
      .hold_req_i(hold_req_i), .hold_lvl_i(hold_lvl_i),
      .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
      .flush_o(flush_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o), .wdt_o(wdt_o)
   );

   // Free-running core clock
   always #5 clk = ~clk;

   // Highest requested level among enabled channels, anything above 3 counts as 3
   function automatic int mergeLevel(input logic [NUM_REQ-1:0] req, input logic [LVL_W-1:0] lvl);
      int best = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int v = int'(lvl[k*HOLD_W +: HOLD_W]);
         if (v > 3) v = 3;
         if (req[k] && v > best) best = v;
      end
      return best;
   endfunction

   function automatic void resetModel();
      m_flush_left = 0;
      m_cnt        = 0;
      m_wdt        = 1'b0;
      m_addr       = '0;
   endfunction

   // Compare the live DUT outputs against one expected response
   task automatic checkOutput(input string name, input resp_t e);
      resp_t a;
      a = '{hold: hold_flag_o, jf: jump_flag_o, addr: jump_addr_o, flush: flush_o,
            busy: busy_o, cnt: stall_cnt_o, wdt: wdt_o};
      checks++;
      if (a !== e) begin
         errors++;
         $display("[TB] FAIL %s @%0t: got hold=%0d jf=%0b addr=%h flush=%0b busy=%0b cnt=%0d wdt=%0b, expected hold=%0d jf=%0b addr=%h flush=%0b busy=%0b cnt=%0d wdt=%0b",
                  name, $time, a.hold, a.jf, a.addr, a.flush, a.busy, a.cnt, a.wdt,
                  e.hold, e.jf, e.addr, e.flush, e.busy, e.cnt, e.wdt);
      end
   endtask

   // Drive one cycle of inputs (called at a falling edge) and queue the expected response
   task automatic applyStimulus(input logic jf, input logic [PC_W-1:0] addr,
                                input logic [NUM_REQ-1:0] req, input logic [LVL_W-1:0] lvl);
      resp_t r;
      int    h;
      int    next_cnt;
      jump_flag_i = jf;
      jump_addr_i = addr;
      hold_req_i  = req;
      hold_lvl_i  = lvl;

      r = '0;
      if (jf) begin
         m_addr       = addr;
         r.jf         = 1'b1;
         r.flush      = 1'b1;
         m_flush_left = FLUSH_CYCLES - 1;
         h            = 0;
      end else if (m_flush_left > 0) begin
         r.flush = 1'b1;
         m_flush_left--;
         h = mergeLevel(req, lvl);
      end else begin
         h = mergeLevel(req, lvl);
      end
      next_cnt = (h != 0) ? ((m_cnt + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt + 1) : 0;
`ifdef STALL_WDT_EN
      if (m_cnt == MAX_STALL) begin
         h        = 0;
         next_cnt = 0;
         m_wdt    = 1'b1;
      end
`endif
      m_cnt  = next_cnt;
      r.addr = m_addr;
      r.hold = HOLD_W'(h);
      r.cnt  = CNT_W'(next_cnt);
      r.wdt  = m_wdt;
      r.busy = r.flush || (h != 0);
      exp_q.push_back(r);
      @(negedge clk);
   endtask

   // Assert reset at a falling edge, confirm outputs clear at once, then release
   task automatic doReset(input string name);
      rst = 1'b1;
      #1;
      checkOutput(name, '0);
      resetModel();
      jump_flag_i = 1'b0;
      jump_addr_i = '0;
      hold_req_i  = '0;
      hold_lvl_i  = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: after each rising edge, pop and compare the oldest expectation
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            checkOutput("cycle", exp_q.pop_front());
         end
      end
   end

   // Global time limit so the run always terminates
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   // Main stimulus sequence
   initial begin
      logic [31:0] rnd;
      int          drain;
      repeat (3) @(negedge clk);
      doReset("reset_initial");

      // Idle after reset
      repeat (20) applyStimulus(1'b0, '0, '0, '0);

      // Channels 0 (lvl 1) and 2 (lvl 3) hold for 5 cycles, channel 1 level ignored
      repeat (5) applyStimulus(1'b0, '0, 3'b101, {3'd3, 3'd7, 3'd1});
      repeat (3) applyStimulus(1'b0, '0, '0, '0);

      // Plain jump
      applyStimulus(1'b1, 32'h0000_0004, '0, '0);
      repeat (4) applyStimulus(1'b0, '0, '0, '0);

      // Jump while channel 1 holds at level 2
      applyStimulus(1'b1, 32'h0000_0040, 3'b010, {3'd0, 3'd2, 3'd0});
      repeat (4) applyStimulus(1'b0, '0, 3'b010, {3'd0, 3'd2, 3'd0});
      repeat (2) applyStimulus(1'b0, '0, '0, '0);

      // Back-to-back jumps
      applyStimulus(1'b1, 32'h0000_0010, '0, '0);
      applyStimulus(1'b1, 32'h0000_0020, '0, '0);
      repeat (4) applyStimulus(1'b0, '0, '0, '0);

      // Level above 3 is clamped
      repeat (3) applyStimulus(1'b0, '0, 3'b001, {3'd0, 3'd0, 3'd6});

      // Reset in the middle of a stall
      repeat (10) applyStimulus(1'b0, '0, 3'b001, {3'd0, 3'd0, 3'd1});
      doReset("reset_mid_stall");

      // Reset in the middle of a flush
      applyStimulus(1'b1, 32'hDEAD_BEE0, '0, '0);
      doReset("reset_mid_flush");
      repeat (2) applyStimulus(1'b0, '0, '0, '0);

      // Long stall: counter saturation, or watchdog release when enabled
      repeat (300) applyStimulus(1'b0, '0, 3'b001, {3'd0, 3'd0, 3'd1});
      repeat (3) applyStimulus(1'b0, '0, '0, '0);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         rnd = $urandom;
         applyStimulus(($urandom_range(0, 7) == 0), $urandom,
                       rnd[NUM_REQ-1:0], rnd[8 +: LVL_W]);
      end
      repeat (3) applyStimulus(1'b0, '0, '0, '0);

      // Wait, bounded, for the monitor to consume every expectation
      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
